lsu_unit: RTL and testbench

- Parametrised load/store execution unit. It replaces the fixed-latency memory ALU with a handshaked bus (grant and read-valid) and a width-generic datapath (XLEN 32 or 64).
- It detects misaligned accesses, detects bus timeouts and reports an error cause code.
- It sits between the issuer and the commiter. It is the only core block that drives the data-memory port.

---
 rtl/core_config_pkg.sv | 42 ++++
 rtl/lsu_extract.sv | 27 ++
 rtl/lsu_unit.sv | 159 +++++++++++++++
 tb/tb_lsu_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// rtl/core_config_pkg.sv - shared core opcodes, LSU state/cause enums and op decode helper
package core_config_pkg;

    typedef enum logic [4:0] {
        c_NOP, c_ADD, c_SUB, c_AND, c_OR, c_XOR,
        c_LB, c_LH, c_LW, c_LBU, c_LHU, c_SB, c_SH, c_SW,
        c_LWU, c_LD, c_SD
    } alu_commands_t;

    typedef enum logic [1:0] {NONE, MISALIGN, BUS_ERR, TIMEOUT} lsu_cause_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} lsu_state_t;

    // size is log2 of the access width in bytes
    typedef struct packed {
        logic       known;
        logic       store;
        logic       sext;
        logic [1:0] size;
    } lsu_op_t;

    function automatic lsu_op_t lsu_decode(input alu_commands_t c, input logic is64);
        lsu_op_t o;
        o = '0;
        case (c)
            c_LB:    o = '{known: 1'b1, store: 1'b0, sext: 1'b1, size: 2'd0};
            c_LH:    o = '{known: 1'b1, store: 1'b0, sext: 1'b1, size: 2'd1};
            c_LW:    o = '{known: 1'b1, store: 1'b0, sext: 1'b1, size: 2'd2};
            c_LBU:   o = '{known: 1'b1, store: 1'b0, sext: 1'b0, size: 2'd0};
            c_LHU:   o = '{known: 1'b1, store: 1'b0, sext: 1'b0, size: 2'd1};
            c_SB:    o = '{known: 1'b1, store: 1'b1, sext: 1'b0, size: 2'd0};
            c_SH:    o = '{known: 1'b1, store: 1'b1, sext: 1'b0, size: 2'd1};
            c_SW:    o = '{known: 1'b1, store: 1'b1, sext: 1'b0, size: 2'd2};
            c_LWU:   if (is64) o = '{known: 1'b1, store: 1'b0, sext: 1'b0, size: 2'd2};
            c_LD:    if (is64) o = '{known: 1'b1, store: 1'b0, sext: 1'b0, size: 2'd3};
            c_SD:    if (is64) o = '{known: 1'b1, store: 1'b1, sext: 1'b0, size: 2'd3};
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// rtl/lsu_extract.sv - load lane select with sign/zero extension
module lsu_extract #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              data,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [1:0]                   size,
    input  logic                         sext,
    output logic [XLEN-1:0]              result
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;

    always_comb begin
        sh = data >> {offset, 3'b000};
        case (size)
            2'd0: begin mask = XLEN'(8'hFF);         sign = sh[7];      end
            2'd1: begin mask = XLEN'(16'hFFFF);      sign = sh[15];     end
            2'd2: begin mask = XLEN'(32'hFFFF_FFFF); sign = sh[31];     end
            default: begin mask = '1;                sign = sh[XLEN-1]; end
        endcase
        result = (sh & mask) | ((sext && sign) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - handshaked load/store unit with misalign, bus error and timeout reporting
module lsu_unit
    import core_config_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [XLEN-1:0]       arg0,
    input  logic [XLEN-1:0]       arg1,
    input  logic [XLEN-1:0]       imm,
    input  alu_commands_t         cmd,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  i_error,
    output logic [XLEN-1:0]       res,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  valid,
    output logic                  o_error,
    output logic [1:0]            o_cause,
    input  logic                  clear,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN/8-1:0]     mem_byteen,
    output logic                  mem_we,
    output logic                  mem_req,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_op_t          dec;
    logic [XLEN-1:0]  ea;
    logic [OFF_W-1:0] off;
    logic             misaligned;
    logic [NB-1:0]    size_mask;
    logic [XLEN-1:0]  wdata_rep;
    logic [XLEN-1:0]  ext_data;

    lsu_state_t            state_q;
    lsu_cause_t            cause_q;
    logic                  store_q, sext_q, err_q;
    logic [1:0]            size_q;
    logic [OFF_W-1:0]      off_q;
    logic [XLEN-1:0]       addr_q, wdata_q, res_q;
    logic [NB-1:0]         byteen_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [TIMEOUT_W-1:0]  cnt_q;

    logic rsp_take, timeout_hit, busy;

    always_comb begin
        dec = lsu_decode(cmd, XLEN == 64);
        ea  = arg0 + imm;
        off = ea[OFF_W-1:0];
        // Replication places every store byte in the lane its offset selects
        case (dec.size)
            2'd0: begin misaligned = 1'b0;     size_mask = NB'(1);     wdata_rep = {NB{arg1[7:0]}};           end
            2'd1: begin misaligned = ea[0];    size_mask = NB'(2'h3);  wdata_rep = {(NB/2){arg1[15:0]}};      end
            2'd2: begin misaligned = |ea[1:0]; size_mask = NB'(4'hF);  wdata_rep = {(XLEN/32){arg1[31:0]}};   end
            default: begin misaligned = |ea[2:0]; size_mask = '1;      wdata_rep = arg1;                      end
        endcase
    end

    lsu_extract #(.XLEN(XLEN)) u_extract (
        .data   (mem_rdata),
        .offset (off_q),
        .size   (size_q),
        .sext   (sext_q),
        .result (ext_data)
    );

    // A response only counts once the request has been (or is being) granted
    assign rsp_take    = ((state_q == REQ) && mem_gnt && mem_rvalid) || ((state_q == WAIT) && mem_rvalid);
    assign timeout_hit = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign busy        = (state_q == REQ) || (state_q == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cause_q  <= NONE;
            store_q  <= 1'b0;
            sext_q   <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            res_q    <= '0;
            byteen_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (issue_valid && dec.known) begin
                    store_q  <= dec.store;
                    sext_q   <= dec.sext;
                    size_q   <= dec.size;
                    off_q    <= off;
                    addr_q   <= {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    byteen_q <= size_mask << off;
                    wdata_q  <= wdata_rep;
                    rd_q     <= i_rd;
                    cnt_q    <= '0;
                    res_q    <= '0;
                    if (misaligned) begin
                        state_q <= OUT;
                        err_q   <= 1'b1;
                        cause_q <= MISALIGN;
                    end else begin
                        state_q <= REQ;
                        err_q   <= 1'b0;
                        cause_q <= NONE;
                    end
                end
                REQ, WAIT: begin
                    if (rsp_take) begin
                        state_q <= OUT;
                        err_q   <= mem_err;
                        cause_q <= mem_err ? BUS_ERR : NONE;
                        res_q   <= (store_q || mem_err) ? '0 : ext_data;
                    end else if (timeout_hit) begin
                        state_q <= OUT;
                        err_q   <= 1'b1;
                        cause_q <= TIMEOUT;
                        res_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + TIMEOUT_W'(1);
                        if ((state_q == REQ) && mem_gnt) state_q <= WAIT;
                    end
                end
                OUT: if (clear) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign i_error     = (state_q == IDLE) && issue_valid && !dec.known;
    assign valid       = (state_q == OUT);
    assign res         = valid ? res_q : '0;
    assign o_rd        = valid ? rd_q : '0;
    assign o_error     = valid && err_q;
    assign o_cause     = valid ? cause_q : 2'd0;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = busy ? addr_q : '0;
    assign mem_byteen  = busy ? byteen_q : '0;
    assign mem_we      = busy && store_q;
    assign mem_wdata   = busy ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed and randomized self-checking bench for lsu_unit
module tb_lsu_unit;
    import core_config_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // 32-bit instance
    logic issue_valid, issue_ready, i_error, valid, o_error, clear;
    logic mem_we, mem_req, mem_gnt, mem_rvalid, mem_err;
    logic [31:0] arg0, arg1, imm, res, mem_addr, mem_wdata, mem_rdata;
    logic [4:0] i_rd, o_rd;
    logic [1:0] o_cause;
    logic [3:0] mem_byteen;
    alu_commands_t cmd;

    lsu_unit dut32 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .arg0(arg0), .arg1(arg1), .imm(imm), .cmd(cmd), .i_rd(i_rd), .i_error(i_error),
        .res(res), .o_rd(o_rd), .valid(valid), .o_error(o_error), .o_cause(o_cause),
        .clear(clear), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_we(mem_we),
        .mem_req(mem_req), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    // 64-bit instance
    logic x_issue_valid, x_issue_ready, x_i_error, x_valid, x_o_error, x_clear;
    logic x_mem_we, x_mem_req, x_mem_gnt, x_mem_rvalid, x_mem_err;
    logic [63:0] x_arg0, x_arg1, x_imm, x_res, x_mem_addr, x_mem_wdata, x_mem_rdata;
    logic [4:0] x_i_rd, x_o_rd;
    logic [1:0] x_o_cause;
    logic [7:0] x_mem_byteen;
    alu_commands_t x_cmd;

    lsu_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .issue_valid(x_issue_valid), .issue_ready(x_issue_ready),
        .arg0(x_arg0), .arg1(x_arg1), .imm(x_imm), .cmd(x_cmd), .i_rd(x_i_rd), .i_error(x_i_error),
        .res(x_res), .o_rd(x_o_rd), .valid(x_valid), .o_error(x_o_error), .o_cause(x_o_cause),
        .clear(x_clear), .mem_addr(x_mem_addr), .mem_byteen(x_mem_byteen), .mem_we(x_mem_we),
        .mem_req(x_mem_req), .mem_wdata(x_mem_wdata), .mem_gnt(x_mem_gnt), .mem_rvalid(x_mem_rvalid),
        .mem_rdata(x_mem_rdata), .mem_err(x_mem_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference load result: take nb bytes at byte offset off, extend to 32 bits
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int nb, input bit sx);
        longint unsigned v;
        v = (longint'(rd) >> (8 * off)) % (64'd1 << (8 * nb));
        if (sx && v >= (64'd1 << (8 * nb - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    task automatic run_op32(input alu_commands_t c, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] im, input logic [4:0] rd, input int gd, input int rv,
                            input bit er, input logic [31:0] rdat);
        int nb, off, t0, reqs;
        bit st, sx, mis;
        logic [31:0] ea, exp_res, exp_wd, wmask;
        logic [3:0] be;
        case (c)
            c_LB:  begin nb = 1; st = 0; sx = 1; end
            c_LH:  begin nb = 2; st = 0; sx = 1; end
            c_LW:  begin nb = 4; st = 0; sx = 1; end
            c_LBU: begin nb = 1; st = 0; sx = 0; end
            c_LHU: begin nb = 2; st = 0; sx = 0; end
            c_SB:  begin nb = 1; st = 1; sx = 0; end
            c_SH:  begin nb = 2; st = 1; sx = 0; end
            default: begin nb = 4; st = 1; sx = 0; end
        endcase
        ea  = a0 + im;
        off = int'(ea % 4);
        mis = (ea % nb) != 0;
        be  = 4'(((1 << nb) - 1) << off);
        exp_res = (st || er) ? 32'h0 : ref_load(rdat, off, nb, sx);
        exp_wd = '0;
        wmask  = '0;
        for (int i = 0; i < 4; i++) if (be[i]) begin
            wmask  = wmask | (32'hFF << (8 * i));
            exp_wd = exp_wd | (((a1 >> (8 * (i - off))) & 32'hFF) << (8 * i));
        end
        issue_valid = 1; cmd = c; arg0 = a0; arg1 = a1; imm = im; i_rd = rd;
        #1;
        chk("issue_ready", issue_ready, 1);
        chk("i_error_known", i_error, 0);
        t0 = cyc;
        tick;
        issue_valid = 0;
        if (mis) begin
            chk("mis_valid", valid, 1);
            chk("mis_o_error", o_error, 1);
            chk("mis_cause", o_cause, 1);
            chk("mis_no_req", mem_req, 0);
            chk("mis_res", res, 0);
            chk("mis_latency", cyc - t0, 1);
        end else begin
            chk("addr", mem_addr, {ea[31:2], 2'b00});
            chk("byteen", mem_byteen, be);
            chk("we", mem_we, st);
            if (st) chk("wdata_lanes", mem_wdata & wmask, exp_wd);
            reqs = 0;
            repeat (gd) begin reqs += int'(mem_req); tick; end
            reqs += int'(mem_req);
            chk("req_cycles", reqs, gd + 1);
            mem_gnt = 1;
            if (rv == 0) begin mem_rvalid = 1; mem_err = er; mem_rdata = rdat; end
            tick;
            mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
            if (rv > 0) begin
                chk("wait_req_low", mem_req, 0);
                chk("wait_addr_held", mem_addr, {ea[31:2], 2'b00});
                repeat (rv - 1) tick;
                mem_rvalid = 1; mem_err = er; mem_rdata = rdat;
                tick;
                mem_rvalid = 0; mem_err = 0;
            end
            chk("valid", valid, 1);
            chk("o_error", o_error, er);
            chk("o_cause", o_cause, er ? 2 : 0);
            chk("res", res, exp_res);
            chk("latency", cyc - t0, 2 + gd + rv);
        end
        chk("o_rd", o_rd, rd);
        clear = 1;
        tick;
        clear = 0;
        chk("after_clear_valid", valid, 0);
        chk("after_clear_ready", issue_ready, 1);
    endtask

    task automatic run_ld64(input alu_commands_t c, input logic [63:0] a0, input logic [63:0] im,
                            input logic [63:0] rdat, input logic [7:0] exp_be, input logic [63:0] exp_res);
        x_issue_valid = 1; x_cmd = c; x_arg0 = a0; x_imm = im; x_i_rd = 5'd9;
        tick;
        x_issue_valid = 0;
        chk("x_byteen", x_mem_byteen, exp_be);
        chk("x_addr", x_mem_addr, {x_arg0[63:3] + x_imm[63:3], 3'b000});
        x_mem_gnt = 1;
        tick;
        x_mem_gnt = 0; x_mem_rvalid = 1; x_mem_rdata = rdat;
        tick;
        x_mem_rvalid = 0;
        chk("x_valid", x_valid, 1);
        chk("x_res", x_res, exp_res);
        x_clear = 1;
        tick;
        x_clear = 0;
    endtask

    alu_commands_t ops[8] = '{c_LB, c_LH, c_LW, c_LBU, c_LHU, c_SB, c_SH, c_SW};

    initial begin
        int k;
        logic [63:0] r64;
        issue_valid = 0; arg0 = 0; arg1 = 0; imm = 0; cmd = c_NOP; i_rd = 0; clear = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        x_issue_valid = 0; x_arg0 = 0; x_arg1 = 0; x_imm = 0; x_cmd = c_NOP; x_i_rd = 0; x_clear = 0;
        x_mem_gnt = 0; x_mem_rvalid = 0; x_mem_rdata = 0; x_mem_err = 0;
        rst_n = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;

        chk("rst_ready", issue_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_byteen", mem_byteen, 0);
        chk("rst_cause", o_cause, 0);
        chk("rst_res", res, 0);

        // Directed cases
        run_op32(c_LB, 32'h1000, 32'h1234_5678, 32'd3, 5'd7, 0, 1, 0, 32'h80FF_FF00);
        run_op32(c_SH, 32'h2000, 32'h1234_ABCD, 32'd2, 5'd3, 0, 1, 0, 32'hDEAD_BEEF);
        run_op32(c_LW, 32'h3000, 32'h0, 32'd1, 5'd4, 0, 1, 0, 32'h0);
        run_op32(c_LHU, 32'h4000, 32'h0, 32'd2, 5'd5, 5, 1, 1, 32'hFFFF_FFFF);
        run_op32(c_LH, 32'h5000, 32'h0, 32'hFFFF_FFFE, 5'd6, 1, 0, 0, 32'hA5A5_8001);

        // Non-LSU and 64-only opcodes are rejected in IDLE
        issue_valid = 1; cmd = c_ADD;
        #1;
        chk("i_error_add", i_error, 1);
        tick;
        cmd = c_LD;
        #1;
        chk("no_accept_add", issue_ready, 1);
        chk("i_error_ld32", i_error, 1);
        tick;
        issue_valid = 0;
        chk("no_accept_ld32", mem_req, 0);

        // Timeout: grant but no response
        issue_valid = 1; cmd = c_LW; arg0 = 32'h6000; imm = 0; i_rd = 5'd2;
        k = cyc;
        tick;
        issue_valid = 0; mem_gnt = 1;
        tick;
        mem_gnt = 0;
        for (int n = 0; n < 300 && !valid; n++) tick;
        chk("to_valid", valid, 1);
        chk("to_latency", cyc - k, 1 + 200);
        chk("to_cause", o_cause, 3);
        chk("to_error", o_error, 1);
        mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick;
        mem_rvalid = 0;
        chk("to_late_cause", o_cause, 3);
        chk("to_late_res", res, 0);
        clear = 1;
        tick;
        clear = 0;
        mem_rvalid = 1;
        tick;
        mem_rvalid = 0;
        chk("idle_rvalid_ignored", valid, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op32(ops[$urandom_range(0, 7)], $urandom, $urandom,
                     32'($urandom_range(0, 31)) - 32'd16, 5'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), $urandom);
        end

        // 64-bit datapath
        run_ld64(c_LD, 64'h0, 64'h8, 64'h8000_0000_0000_0001, 8'hFF, 64'h8000_0000_0000_0001);
        run_ld64(c_LW, 64'h0, 64'h4, 64'h8000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0001);
        run_ld64(c_LWU, 64'h10, 64'h4, 64'h8000_0001_0000_0000, 8'hF0, 64'h0000_0000_8000_0001);

        // Async reset while waiting for a response
        x_issue_valid = 1; x_cmd = c_LD; x_arg0 = 64'h100; x_imm = 0;
        tick;
        x_issue_valid = 0; x_mem_gnt = 1;
        tick;
        x_mem_gnt = 0;
        chk("x_in_wait", x_mem_addr, 64'h100);
        #2 rst_n = 0;
        #1;
        chk("x_rst_ready", x_issue_ready, 1);
        chk("x_rst_addr", x_mem_addr, 0);
        chk("x_rst_byteen", x_mem_byteen, 0);
        chk("x_rst_valid", x_valid, 0);
        #1 rst_n = 1;
        tick;
        r64 = {$urandom, $urandom};
        x_mem_rvalid = 1; x_mem_rdata = r64;
        tick;
        x_mem_rvalid = 0;
        chk("x_post_rst_rvalid", x_valid, 0);
        chk("x_post_rst_res", x_res, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
